conv_interleaver_param: RTL

- Parametrised Forney convolutional interleaver/deinterleaver built from enable-gated register delay lines, with no RAM.
- BRANCHES branches; branch b delays by a multiple of DEPTH_STEP symbols, selected round-robin by a commutator.
- Sits between the outer encoder and the inner coder on TX. Instantiated with MODE=1 on RX.
- Adds what a fixed delay line lacks: runtime-free generalisation, commutator, sync alignment, valid/primed status.

---
 rtl/conv_interleaver_param.sv | 85 ++++++++
 1 files changed

// File: rtl/conv_interleaver_param.sv
// Forney convolutional interleaver/deinterleaver built from enable-gated register
// delay lines with a sync-alignable commutator and fill tracking.
module conv_interleaver_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BRANCHES   = 12,
    parameter int unsigned DEPTH_STEP = 17,
    parameter int unsigned MODE       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              buf_en,
    input  logic              sync_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              sync_out,
    output logic              primed
);

    localparam int unsigned CMT_W  = $clog2(BRANCHES);
    localparam int unsigned FILL   = BRANCHES * (BRANCHES - 1) * DEPTH_STEP;
    localparam int unsigned FILL_W = $clog2(FILL + 1);

    logic [CMT_W-1:0]  cmt;
    logic [CMT_W-1:0]  sel;
    logic [FILL_W-1:0] fill_cnt;
    logic [DATA_W-1:0] branch_out [BRANCHES];
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        sel = cmt;
        if (buf_en && sync_in) sel = '0;
    end

    for (genvar b = 0; b < BRANCHES; b++) begin : g_branch
        localparam int unsigned LEN = (MODE == 0) ? b * DEPTH_STEP
                                                  : (BRANCHES - 1 - b) * DEPTH_STEP;
        if (LEN == 0) begin : g_wire
            assign branch_out[b] = data_in;
        end else begin : g_line
            logic [DATA_W-1:0] line [LEN];

            // Only the selected branch advances; index LEN-1 holds the oldest symbol.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int unsigned i = 0; i < LEN; i++) line[i] <= '0;
                end else if (buf_en && sel == CMT_W'(b)) begin
                    line[0] <= data_in;
                    for (int unsigned i = 1; i < LEN; i++) line[i] <= line[i-1];
                end
            end

            assign branch_out[b] = line[LEN-1];
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned b = 0; b < BRANCHES; b++) begin
            if (sel == CMT_W'(b)) sel_data = branch_out[b];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmt       <= '0;
            fill_cnt  <= '0;
            primed    <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            sync_out  <= 1'b0;
        end else if (buf_en) begin
            cmt       <= (sel == CMT_W'(BRANCHES - 1)) ? '0 : sel + 1'b1;
            data_out  <= sel_data;
            out_valid <= 1'b1;
            sync_out  <= (sel == '0);
            if (fill_cnt != FILL_W'(FILL)) fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_W'(FILL - 1)) primed <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            sync_out  <= 1'b0;
        end
    end

endmodule
